// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if
//  Bundles the memory port and the execute-side request/response signals of
//  the PC / fetch / memory-sequencing unit.
//  master : the sequencer (drives mem_addr, mem_cmd, ir, instr_valid, pc,
//           ddone, drdata, halted and, with BR_COUNT_EN, br_taken_cnt)
//  slave  : memory + execute FSM/datapath (drives read_data, flags, requests)
//  Optional macro: BR_COUNT_EN adds br_taken_cnt (16 bit).
interface pc_fetch_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] read_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_cmd;
    logic [DATA_W-1:0] ir;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              N, V, Z;
    logic              next_req;
    logic              br_req;
    logic [2:0]        br_cond;
    logic [7:0]        br_off;
    logic              bx_req;
    logic [ADDR_W-1:0] bx_target;
    logic              dreq, dwe;
    logic [ADDR_W-1:0] daddr;
    logic              ddone;
    logic [DATA_W-1:0] drdata;
    logic              halt_req;
    logic              halted;
`ifdef BR_COUNT_EN
    logic [15:0]       br_taken_cnt;
`endif

    modport master (
`ifdef BR_COUNT_EN
        output br_taken_cnt,
`endif
        output mem_addr, mem_cmd, ir, instr_valid, pc, ddone, drdata, halted,
        input  read_data, N, V, Z, next_req, br_req, br_cond, br_off,
               bx_req, bx_target, dreq, dwe, daddr, halt_req
    );

    modport slave (
`ifdef BR_COUNT_EN
        input  br_taken_cnt,
`endif
        input  mem_addr, mem_cmd, ir, instr_valid, pc, ddone, drdata, halted,
        output read_data, N, V, Z, next_req, br_req, br_cond, br_off,
               bx_req, bx_target, dreq, dwe, daddr, halt_req
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//  Program counter, instruction register and single memory port sequencer for
//  the multi-cycle core. Fetches with MEM_LAT-cycle accesses, resolves
//  B/Bcc/BL/BX targets and runs execute-stage loads/stores on the same port.
// Ports
//  clk   : clock, all state on rising edge
//  reset : asynchronous active-high reset
//  bus   : pc_fetch_sequencer_if.master (memory port, ir/pc/instr_valid,
//          branch/data/halt requests, ddone/drdata, halted)
// Optional macro: BR_COUNT_EN adds a saturating 16-bit taken-branch counter
//  (B/Bcc/BX) on bus.br_taken_cnt.
module pc_fetch_sequencer #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16,
    parameter int MEM_LAT  = 2,
    parameter int RESET_PC = 0
) (
    input logic                 clk,
    input logic                 reset,
    pc_fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_RST, S_FETCH, S_EXEC, S_DATA, S_HALT} state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam int EXT_W = (ADDR_W > 8) ? ADDR_W : 8;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] pc_q, mem_addr_q;
    logic [DATA_W-1:0] ir_q, drdata_q;
    logic [1:0]        mem_cmd_q;
    logic              iv_q, ddone_q, halted_q, dwe_q;

    // Branch resolution; pc_q already points past the branch instruction.
    logic              br_taken, go_fetch;
    logic [EXT_W-1:0]  off_ext;
    logic [ADDR_W-1:0] br_target, fetch_pc;

    assign off_ext   = EXT_W'($signed(bus.br_off));
    assign br_target = pc_q + off_ext[ADDR_W-1:0];

    always_comb begin
        br_taken = 1'b0;
        case (bus.br_cond)
            3'b000:  br_taken = 1'b1;
            3'b001:  br_taken = bus.Z;
            3'b010:  br_taken = !bus.Z;
            3'b011:  br_taken = bus.N ^ bus.V;
            3'b100:  br_taken = (bus.N ^ bus.V) | bus.Z;
            default: br_taken = 1'b0;
        endcase
    end

    // Priority below halt: bx > br > next all lead to a fetch; only the
    // fetch address differs. A not-taken branch refetches at pc_q.
    assign go_fetch = bus.bx_req | bus.br_req | bus.next_req;
    assign fetch_pc = bus.bx_req ? bus.bx_target :
                      (bus.br_req && br_taken) ? br_target : pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_RST;
            cnt        <= '0;
            pc_q       <= ADDR_W'(RESET_PC);
            mem_addr_q <= '0;
            mem_cmd_q  <= CMD_NONE;
            ir_q       <= '0;
            drdata_q   <= '0;
            iv_q       <= 1'b0;
            ddone_q    <= 1'b0;
            halted_q   <= 1'b0;
            dwe_q      <= 1'b0;
        end else begin
            ddone_q <= 1'b0;
            case (state)
                S_RST: begin
                    state      <= S_FETCH;
                    mem_addr_q <= pc_q;
                    mem_cmd_q  <= CMD_READ;
                    cnt        <= CNT_LAST;
                end
                S_FETCH: begin
                    if (cnt == '0) begin
                        ir_q       <= bus.read_data;
                        pc_q       <= pc_q + ADDR_W'(1);
                        mem_addr_q <= pc_q + ADDR_W'(1);
                        mem_cmd_q  <= CMD_NONE;
                        iv_q       <= 1'b1;
                        state      <= S_EXEC;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_EXEC: begin
                    if (bus.halt_req) begin
                        halted_q <= 1'b1;
                        iv_q     <= 1'b0;
                        state    <= S_HALT;
                    end else if (go_fetch) begin
                        pc_q       <= fetch_pc;
                        mem_addr_q <= fetch_pc;
                        mem_cmd_q  <= CMD_READ;
                        cnt        <= CNT_LAST;
                        iv_q       <= 1'b0;
                        state      <= S_FETCH;
                    end else if (bus.dreq) begin
                        // mem_addr_q doubles as the latched data address.
                        mem_addr_q <= bus.daddr;
                        dwe_q      <= bus.dwe;
                        mem_cmd_q  <= bus.dwe ? CMD_WRITE : CMD_READ;
                        cnt        <= CNT_LAST;
                        iv_q       <= 1'b0;
                        state      <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        if (!dwe_q) drdata_q <= bus.read_data;
                        ddone_q    <= 1'b1;
                        mem_cmd_q  <= CMD_NONE;
                        mem_addr_q <= pc_q;
                        iv_q       <= 1'b1;
                        state      <= S_EXEC;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HALT: ;
                default: state <= S_RST;
            endcase
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_cmd     = mem_cmd_q;
    assign bus.ir          = ir_q;
    assign bus.instr_valid = iv_q;
    assign bus.pc          = pc_q;
    assign bus.ddone       = ddone_q;
    assign bus.drdata      = drdata_q;
    assign bus.halted      = halted_q;

`ifdef BR_COUNT_EN
    logic        taken_evt;
    logic [15:0] br_cnt_q;

    assign taken_evt = (state == S_EXEC) && !bus.halt_req &&
                       (bus.bx_req || (bus.br_req && br_taken));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            br_cnt_q <= '0;
        else if (taken_evt && br_cnt_q != 16'hFFFF)
            br_cnt_q <= br_cnt_q + 16'd1;
    end

    assign bus.br_taken_cnt = br_cnt_q;
`endif
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;
    localparam int EV_ACC = 0, EV_IV = 1, EV_DD = 2, EV_HLT = 3;

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0, bad = 0;
    ev_t exq[$];
    logic [15:0] mem [0:511];

    pc_fetch_sequencer_if #(.ADDR_W(9), .DATA_W(16)) bus ();
    pc_fetch_sequencer #(.ADDR_W(9), .DATA_W(16), .MEM_LAT(2), .RESET_PC(0))
        dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    assign bus.read_data = mem[bus.mem_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c;
        exq.push_back(e);
    endtask

    task automatic exp_fetch(input logic [8:0] addr, input logic [8:0] npc);
        push(EV_ACC, 16'd1, {7'd0, addr}, 16'd2);
        push(EV_IV, mem[addr], {7'd0, npc}, 16'd0);
    endtask

    // Monitor: turns DUT output activity into events and scores them.
    logic [1:0]  prev_cmd = 2'b00, a_cmd = 2'b00;
    logic [8:0]  a_addr = '0;
    logic [15:0] a_len = '0;
    logic        prev_iv = 1'b0, prev_h = 1'b0;

    task automatic obs(input int k, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        ev_t e;
        total++;
        if (exq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d a=%h b=%h c=%h want none", k, a, b, c);
        end else begin
            e = exq.pop_front();
            if (e.kind != k || e.a !== a || e.b !== b || e.c !== c) begin
                bad++;
                $display("FAIL event: got kind=%0d a=%h b=%h c=%h want kind=%0d a=%h b=%h c=%h",
                         k, a, b, c, e.kind, e.a, e.b, e.c);
            end
        end
    endtask

    always @(negedge clk) begin
        if (prev_cmd == 2'b00 && bus.mem_cmd != 2'b00) begin
            a_cmd = bus.mem_cmd; a_addr = bus.mem_addr; a_len = 16'd1;
        end else if (prev_cmd != 2'b00 && bus.mem_cmd != 2'b00) begin
            a_len = a_len + 16'd1;
        end else if (prev_cmd != 2'b00 && bus.mem_cmd == 2'b00) begin
            obs(EV_ACC, {14'd0, a_cmd}, {7'd0, a_addr}, a_len);
        end
        if (bus.ddone) obs(EV_DD, bus.drdata, {7'd0, bus.pc}, bus.ir);
        if (bus.instr_valid && !prev_iv && !bus.ddone) obs(EV_IV, bus.ir, {7'd0, bus.pc}, 16'd0);
        if (bus.halted && !prev_h) obs(EV_HLT, 16'd0, 16'd0, 16'd0);
        prev_cmd = bus.mem_cmd;
        prev_iv  = bus.instr_valid;
        prev_h   = bus.halted;
    end

    task automatic clear_reqs();
        bus.next_req = 0; bus.br_req = 0; bus.bx_req = 0; bus.dreq = 0;
        bus.halt_req = 0; bus.dwe = 0;
    endtask

    task automatic wait_exec();
        for (int i = 0; i < 50; i++) begin
            if (bus.instr_valid) return;
            @(negedge clk);
        end
        chk("wait_exec_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse();
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic branch(input logic [2:0] cond, input logic [7:0] off,
                          input logic n, input logic v, input logic z,
                          input logic [8:0] faddr, input logic [8:0] npc);
        wait_exec();
        bus.N = n; bus.V = v; bus.Z = z;
        bus.br_cond = cond; bus.br_off = off; bus.br_req = 1;
        exp_fetch(faddr, npc);
        pulse();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h3000 + 16'(i * 7);
        mem[9'h040] = 16'hBEEF;
        clear_reqs();
        bus.N = 0; bus.V = 0; bus.Z = 0; bus.br_cond = 0; bus.br_off = 0;
        bus.bx_target = 0; bus.daddr = 0;

        repeat (2) @(negedge clk);
        chk("rst_mem_cmd", {30'd0, bus.mem_cmd}, 32'd0);
        chk("rst_pc", {23'd0, bus.pc}, 32'd0);
        chk("rst_ir", {16'd0, bus.ir}, 32'd0);
        chk("rst_iv", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_ddone", {31'd0, bus.ddone}, 32'd0);
        chk("rst_drdata", {16'd0, bus.drdata}, 32'd0);

        exp_fetch(9'd0, 9'd1);
        reset = 0;

        for (int a = 1; a <= 4; a++) begin
            wait_exec();
            bus.next_req = 1;
            exp_fetch(9'(a), 9'(a + 1));
            pulse();
        end
        branch(3'b001, 8'hFE, 0, 0, 1, 9'd3, 9'd4);    // EQ taken 5-2
        wait_exec(); bus.next_req = 1; exp_fetch(9'd4, 9'd5); pulse();
        branch(3'b001, 8'hFE, 0, 0, 0, 9'd5, 9'd6);    // EQ not taken
        branch(3'b100, 8'h04, 1, 0, 0, 9'd10, 9'd11);  // LE taken
        branch(3'b011, 8'h04, 1, 1, 0, 9'd11, 9'd12);  // LT not taken
        branch(3'b111, 8'h04, 0, 0, 1, 9'd12, 9'd13);  // never
        branch(3'b000, 8'h80, 0, 0, 0, 9'h18D, 9'h18E); // B -128 wraps
        branch(3'b010, 8'h02, 0, 0, 0, 9'h190, 9'h191); // NE taken
        branch(3'b011, 8'hFF, 1, 0, 0, 9'h190, 9'h191); // LT taken -1

        wait_exec();
        bus.dreq = 1; bus.dwe = 0; bus.daddr = 9'h040;
        push(EV_ACC, 16'd1, 16'h0040, 16'd2);
        push(EV_DD, 16'hBEEF, 16'h0191, mem[9'h190]);
        pulse();
        wait_exec();
        bus.dreq = 1; bus.dwe = 1; bus.daddr = 9'h041;
        push(EV_ACC, 16'd2, 16'h0041, 16'd2);
        push(EV_DD, 16'hBEEF, 16'h0191, mem[9'h190]);
        pulse();

        wait_exec();
        bus.next_req = 1; bus.dreq = 1; bus.daddr = 9'h041;
        exp_fetch(9'h191, 9'h192);
        pulse();
        wait_exec();
        bus.bx_req = 1; bus.bx_target = 9'h1FF; bus.br_req = 1; bus.br_cond = 3'b000; bus.br_off = 8'h10;
        exp_fetch(9'h1FF, 9'h000);
        pulse();
        wait_exec();
        bus.bx_req = 1; bus.bx_target = 9'h012;
        exp_fetch(9'h012, 9'h013);
        pulse();

        wait_exec();
        bus.halt_req = 1; bus.next_req = 1;
        push(EV_HLT, 16'd0, 16'd0, 16'd0);
        pulse();
        repeat (20) @(negedge clk);
        chk("halt_mem_cmd", {30'd0, bus.mem_cmd}, 32'd0);
        chk("halt_halted", {31'd0, bus.halted}, 32'd1);
        chk("halt_iv", {31'd0, bus.instr_valid}, 32'd0);
        chk("halt_pc", {23'd0, bus.pc}, 32'h013);
`ifdef BR_COUNT_EN
        chk("br_taken_cnt", {16'd0, bus.br_taken_cnt}, 32'd7);
`endif

        reset = 1;
        @(negedge clk);
        chk("rst2_pc", {23'd0, bus.pc}, 32'd0);
        chk("rst2_halted", {31'd0, bus.halted}, 32'd0);
        exp_fetch(9'd0, 9'd1);
        reset = 0;

        wait_exec();
        bus.dreq = 1; bus.dwe = 0; bus.daddr = 9'h040;
        push(EV_ACC, 16'd1, 16'h0040, 16'd1);
        pulse();
        chk("mid_data_cmd", {30'd0, bus.mem_cmd}, 32'd1);
        #2 reset = 1;
        #1 chk("abort_mem_cmd", {30'd0, bus.mem_cmd}, 32'd0);
        exp_fetch(9'd0, 9'd1);
        repeat (2) @(negedge clk);
        chk("abort_drdata", {16'd0, bus.drdata}, 32'd0);
        reset = 0;
        wait_exec();
        @(negedge clk);
        chk("queue_empty", exq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
